// File: rtl/mips_pkg.sv
// Shared MIPS32 encoding constants and control-transfer state type.
package mips_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    localparam logic [31:0] RESET_PC  = 32'h0000_3000;

    typedef enum logic {
        IDLE = 1'b0,
        SLOT = 1'b1
    } redirect_state_t;

endpackage

// File: rtl/branch_condition.sv
// Combinational branch outcome for conditional branches and J/JAL.
// JR/JALR are resolved in the top, since they need the funct field.
module branch_condition
    import mips_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [4:0]  rt_field,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:  taken = (rs_value == rt_value);
            OP_BNE:  taken = (rs_value != rt_value);
            OP_BLEZ: taken = ($signed(rs_value) <= 32'sd0);
            OP_BGTZ: taken = ($signed(rs_value) >  32'sd0);
            OP_REGIMM: begin
                // Only BLTZ (rt=0) and BGEZ (rt=1) are recognised here
                if (rt_field == 5'd0)
                    taken = rs_value[31];
                else if (rt_field == 5'd1)
                    taken = ~rs_value[31];
            end
            OP_J, OP_JAL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_redirect_unit.sv
// Drives the PC jump interface from control-transfer instructions, holding
// each redirect for one cycle so exactly one delay-slot instruction executes.
module branch_redirect_unit
    import mips_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:2] pc_value,
    input  logic [31:0] instruction,
    input  logic [31:0] rs_value,
    input  logic [31:0] rt_value,
    output logic        jump_enable,
    output logic [31:2] jump_input,
    output logic        link_write,
    output logic [4:0]  link_reg,
    output logic [31:0] link_value,
    output logic        address_error
);

    redirect_state_t state;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd_field;
    logic [29:0] pc_plus1;
    logic [29:0] branch_offset;
    logic        cond_taken;
    logic        is_jump_imm;
    logic        is_jump_reg;
    logic        is_jal;
    logic        is_jalr;
    logic        reg_misaligned;
    logic        take_redirect;
    logic        raise_error;
    logic [29:0] target;

    assign opcode        = instruction[31:26];
    assign funct         = instruction[5:0];
    assign rd_field      = instruction[15:11];
    assign pc_plus1      = pc_value + 30'd1;
    assign branch_offset = {{14{instruction[15]}}, instruction[15:0]};

    branch_condition u_condition (
        .opcode   (opcode),
        .rt_field (instruction[20:16]),
        .rs_value (rs_value),
        .rt_value (rt_value),
        .taken    (cond_taken)
    );

    assign is_jal         = (opcode == OP_JAL);
    assign is_jump_imm    = (opcode == OP_J) || is_jal;
    assign is_jalr        = (opcode == OP_SPECIAL) && (funct == FN_JALR);
    assign is_jump_reg    = (opcode == OP_SPECIAL) && ((funct == FN_JR) || is_jalr);
    assign reg_misaligned = (rs_value[1:0] != 2'b00);

    // A misaligned register jump raises an error instead of redirecting
    assign take_redirect  = (state == IDLE) &&
                            (cond_taken || (is_jump_reg && !reg_misaligned));
    assign raise_error    = (state == IDLE) && is_jump_reg && reg_misaligned;

    always_comb begin
        target = pc_plus1 + branch_offset;
        if (is_jump_imm)
            target = {pc_plus1[29:26], instruction[25:0]};
        else if (is_jump_reg)
            target = rs_value[31:2];
    end

    assign link_write = (state == IDLE) && (is_jal || (is_jalr && (rd_field != 5'd0)));
    assign link_reg   = is_jal ? 5'd31 : rd_field;
    assign link_value = {pc_value + 30'd2, 2'b00};

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= IDLE;
            jump_enable   <= 1'b0;
            jump_input    <= RESET_PC[31:2];
            address_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    jump_enable   <= take_redirect;
                    address_error <= raise_error;
                    if (take_redirect) begin
                        jump_input <= target;
                        state      <= SLOT;
                    end
                end
                SLOT: begin
                    // Delay slot: any control transfer here is ignored
                    jump_enable   <= 1'b0;
                    address_error <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    jump_enable   <= 1'b0;
                    address_error <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule
